seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_encoder.sv | 16 +
 rtl/seg7_scan_driver.sv | 153 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment driver: hex glyph table,
// blank pattern, DP bit position and the digit-index width helper.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'h00;
  localparam int         SEG_DP_BIT = 7;

  // Index 15 is the leftmost element; glyph bits are {DP,G,F,E,D,C,B,A}.
  localparam logic [15:0][7:0] HEX_GLYPH = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  function automatic int dig_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Combinational nibble + decimal point to {DP,G,F,E,D,C,B,A} segment pattern.
module seg7_encoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] segments
);

  always_comb begin
    segments = blank ? SEG_BLANK : HEX_GLYPH[nibble];
    segments[SEG_DP_BIT] = segments[SEG_DP_BIT] | dp;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous double-buffered
// updates and PWM brightness. Optional: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 150000,
  parameter int BRIGHT_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] upd_value,
  input  logic [NUM_DIGITS-1:0]   upd_dp,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  output logic                    upd_done,
  input  logic [BRIGHT_W-1:0]     bright,
  output logic [NUM_DIGITS-1:0]   digits,
  output logic [7:0]              segments
);

  localparam int VAL_W  = 4 * NUM_DIGITS;
  localparam int IDX_W  = dig_idx_w(NUM_DIGITS);
  localparam int TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
  logic [VAL_W-1:0]      act_val_q, act_val_d, shd_val_q, shd_val_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, shd_dp_q, shd_dp_d;
  logic                  pending_q, pending_d;
  logic                  done_q, done_d;
  logic [NUM_DIGITS-1:0] digits_q, digits_d;
  logic [7:0]            segments_q, segments_d;

  logic                  tick_wrap, frame_end, xfer, apply, pwm_on;
  logic [3:0]            sel_nib;
  logic                  sel_dp, sel_blank;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [7:0]            enc_seg;

  // upd_valid/upd_ready: a transfer happens in any cycle where both are high;
  // the requester keeps upd_valid asserted until it sees upd_ready.
  assign tick_wrap = (tick_q == TICK_LAST);
  assign frame_end = tick_wrap && (idx_q == IDX_LAST);
  assign xfer      = upd_valid && !pending_q;
  assign apply     = frame_end && pending_q;
  assign pwm_on    = (pwm_q <= bright);

  always_comb begin
    tick_d    = tick_wrap ? '0 : tick_q + TICK_W'(1);
    idx_d     = idx_q;
    if (tick_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    pwm_d     = pwm_q + BRIGHT_W'(1);
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    shd_val_d = shd_val_q;
    shd_dp_d  = shd_dp_q;
    pending_d = pending_q;
    // A shadow captured on the boundary cycle itself waits a full frame.
    if (apply) begin
      act_val_d = shd_val_q;
      act_dp_d  = shd_dp_q;
      pending_d = 1'b0;
    end else if (xfer) begin
      shd_val_d = upd_value;
      shd_dp_d  = upd_dp;
      pending_d = 1'b1;
    end
    done_d = apply;
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above  = zero_above && (act_val_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_above && (i != 0);
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_nib   = act_val_q[4*i +: 4];
        sel_dp    = act_dp_q[i];
        sel_blank = lz_blank[i];
      end
    end
  end

  seg7_encoder u_enc (
    .nibble   (sel_nib),
    .dp       (sel_dp),
    .blank    (sel_blank),
    .segments (enc_seg)
  );

  always_comb begin
    digits_d   = '1;
    segments_d = SEG_BLANK;
    if (pwm_on) begin
      segments_d = enc_seg;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) digits_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q     <= '0;
      idx_q      <= '0;
      pwm_q      <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      shd_val_q  <= '0;
      shd_dp_q   <= '0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
      digits_q   <= '1;
      segments_q <= SEG_BLANK;
    end else begin
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      pwm_q      <= pwm_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      shd_val_q  <= shd_val_d;
      shd_dp_q   <= shd_dp_d;
      pending_q  <= pending_d;
      done_q     <= done_d;
      digits_q   <= digits_d;
      segments_q <= segments_d;
    end
  end

  assign upd_ready = !pending_q;
  assign upd_done  = done_q;
  assign digits    = digits_q;
  assign segments  = segments_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: per-cycle reference model, vector table and
// hand-written handshake / brightness / reset sequences.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] upd_value = '0;
  logic [3:0]  upd_dp = '0;
  logic        upd_valid = 1'b0;
  logic        upd_ready, upd_done;
  logic [3:0]  bright = 4'hF;
  logic [3:0]  digits;
  logic [7:0]  segments;

  logic [11:0] upd_value3 = '0;
  logic [2:0]  upd_dp3 = '0;
  logic        upd_valid3 = 1'b0;
  logic        upd_ready3, upd_done3;
  logic [3:0]  bright3 = 4'hF;
  logic [2:0]  digits3;
  logic [7:0]  segments3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BRIGHT_W(4)) dut (
    .clk(clk), .rst(rst), .upd_value(upd_value), .upd_dp(upd_dp),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_done(upd_done),
    .bright(bright), .digits(digits), .segments(segments)
  );

  seg7_scan_driver #(.NUM_DIGITS(3), .REFRESH_DIV(2), .BRIGHT_W(4)) dut3 (
    .clk(clk), .rst(rst), .upd_value(upd_value3), .upd_dp(upd_dp3),
    .upd_valid(upd_valid3), .upd_ready(upd_ready3), .upd_done(upd_done3),
    .bright(bright3), .digits(digits3), .segments(segments3)
  );

  logic [7:0] glyph_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Display for scan position n (cycles since reset release) from the frame arithmetic.
  function automatic void model_disp(input int n, input logic [15:0] val, input logic [3:0] dp,
                                     input logic [3:0] br, output logic [3:0] dg, output logic [7:0] sg);
    int idx;
    logic [15:0] upper;
    idx = (n / RD) % ND;
    dg = 4'hF;
    sg = 8'h00;
    if ((n % 16) <= int'(br)) begin
      dg[idx] = 1'b0;
      upper = val >> (4 * idx);
      sg = glyph_tab[upper[3:0]];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (idx != 0 && upper == 16'h0) sg = 8'h00;
`endif
      if (dp[idx]) sg[7] = 1'b1;
    end
  endfunction

  // Reference model state: m_n is the scan position the DUT is in after the latest edge.
  int          m_n = 0;
  logic [15:0] m_act = '0, m_shd = '0;
  logic [3:0]  m_adp = '0, m_sdp = '0;
  logic        m_pend = 1'b0;
  logic        chk_en = 1'b0;
  logic [3:0]  e_dig = 4'hF;
  logic [7:0]  e_seg = '0;
  logic        e_rdy = 1'b1, e_done = 1'b0;
  logic [2:0]  e_dig3 = 3'b111;
  logic [7:0]  e_seg3 = '0;

  initial forever begin
    @(posedge clk);
    chk_en = 1'b1;
    if (rst) begin
      m_n = 0; m_act = '0; m_adp = '0; m_pend = 1'b0;
      e_dig = 4'hF; e_seg = 8'h00; e_rdy = 1'b1; e_done = 1'b0;
      e_dig3 = 3'b111; e_seg3 = 8'h00;
    end else begin
      model_disp(m_n, m_act, m_adp, bright, e_dig, e_seg);
      e_dig3 = 3'b111;
      e_dig3[(m_n / 2) % 3] = 1'b0;
      e_seg3 = 8'h3F;
      e_done = m_pend && ((m_n % FRAME) == FRAME - 1);
      if (e_done) begin
        m_act = m_shd; m_adp = m_sdp; m_pend = 1'b0;
      end else if (upd_valid && !m_pend) begin
        m_shd = upd_value; m_sdp = upd_dp; m_pend = 1'b1;
      end
      e_rdy = !m_pend;
      m_n++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("model_digits", 32'(digits), 32'(e_dig));
      chk("model_segments", 32'(segments), 32'(e_seg));
      chk("model_ready", 32'(upd_ready), 32'(e_rdy));
      chk("model_done", 32'(upd_done), 32'(e_done));
      chk("model_digits3", 32'(digits3), 32'(e_dig3));
      chk("model_segments3", 32'(segments3), 32'(e_seg3));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!upd_ready && k < 64) begin cycle(); k++; end
    if (!upd_ready) chk("ready_timeout", 32'(upd_ready), 32'd1);
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!upd_done && k < 64) begin cycle(); k++; end
    if (!upd_done) chk("done_timeout", 32'(upd_done), 32'd1);
  endtask

  task automatic wait_pos(input int target);
    int g = 0;
    while ((m_n % FRAME) != target && g < 64) begin cycle(); g++; end
  endtask

  task automatic load_value(input logic [15:0] v, input logic [3:0] dp);
    int k;
    wait_ready();
    upd_valid = 1'b1; upd_value = v; upd_dp = dp;
    cycle();
    upd_valid = 1'b0;
    wait_done(k);
  endtask

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    int          digit;
    logic [3:0]  exp_digits;
    logic [7:0]  exp_seg;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int k, cnt, g;
    logic [15:0] cur_val;
    logic [3:0]  cur_dp;

    vecs[0]  = '{16'h1234, 4'b0000, 0, 4'b1110, 8'h66};
    vecs[1]  = '{16'h1234, 4'b0000, 1, 4'b1101, 8'h4F};
    vecs[2]  = '{16'h1234, 4'b0000, 2, 4'b1011, 8'h5B};
    vecs[3]  = '{16'h1234, 4'b0000, 3, 4'b0111, 8'h06};
    vecs[4]  = '{16'h1234, 4'b0000, 0, 4'b1110, 8'h66};
    vecs[5]  = '{16'hABCD, 4'b0101, 0, 4'b1110, 8'hDE};
    vecs[6]  = '{16'hABCD, 4'b0101, 1, 4'b1101, 8'h39};
    vecs[7]  = '{16'hABCD, 4'b0101, 2, 4'b1011, 8'hFC};
    vecs[8]  = '{16'hABCD, 4'b0101, 3, 4'b0111, 8'h77};
    vecs[9]  = '{16'h0050, 4'b1000, 0, 4'b1110, 8'h3F};
    vecs[10] = '{16'h0050, 4'b1000, 1, 4'b1101, 8'h6D};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    vecs[11] = '{16'h0050, 4'b1000, 2, 4'b1011, 8'h00};
    vecs[12] = '{16'h0050, 4'b1000, 3, 4'b0111, 8'h80};
`else
    vecs[11] = '{16'h0050, 4'b1000, 2, 4'b1011, 8'h3F};
    vecs[12] = '{16'h0050, 4'b1000, 3, 4'b0111, 8'hBF};
`endif
    vecs[13] = '{16'hEF98, 4'b0000, 0, 4'b1110, 8'h7F};
    vecs[14] = '{16'hEF98, 4'b0000, 2, 4'b1011, 8'h71};
    vecs[15] = '{16'hEF98, 4'b0000, 3, 4'b0111, 8'h79};

    // Reset held three cycles, then first registered output after release.
    repeat (3) cycle();
    chk("rst_digits", 32'(digits), 32'hF);
    chk("rst_segments", 32'(segments), 32'h0);
    chk("rst_ready", 32'(upd_ready), 32'd1);
    chk("rst_done", 32'(upd_done), 32'd0);
    chk("rst_digits3", 32'(digits3), 32'h7);
    rst = 1'b0;
    cycle();
    chk("first_digits", 32'(digits), 32'hE);
    chk("first_segments", 32'(segments), 32'h3F);

    // Vector table: load a value, then sample each digit mid-slot.
    cur_val = '0; cur_dp = '0;
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].value != cur_val || vecs[i].dp != cur_dp) begin
        load_value(vecs[i].value, vecs[i].dp);
        cur_val = vecs[i].value; cur_dp = vecs[i].dp;
      end
      g = 0;
      while (((m_n - 1) % FRAME) != 4 * vecs[i].digit + 1 && g < 64) begin cycle(); g++; end
      chk($sformatf("vec%0d_digits", i), 32'(digits), 32'(vecs[i].exp_digits));
      chk($sformatf("vec%0d_segments", i), 32'(segments), 32'(vecs[i].exp_seg));
    end

    // Mid-frame transfer: ready drops, done arrives at the frame boundary.
    wait_ready();
    wait_pos(5);
    upd_valid = 1'b1; upd_value = 16'h5678; upd_dp = 4'b0010;
    cycle();
    upd_valid = 1'b0;
    chk("hs_ready_low", 32'(upd_ready), 32'd0);
    wait_done(k);
    chk("hs_done_latency", 32'(k), 32'd10);
    chk("hs_ready_back", 32'(upd_ready), 32'd1);
    cycle();
    chk("hs_done_one_cycle", 32'(upd_done), 32'd0);

    // Transfer on the boundary cycle itself waits one full frame.
    wait_pos(FRAME - 1);
    upd_valid = 1'b1; upd_value = 16'h9ABC; upd_dp = 4'b0000;
    cycle();
    upd_valid = 1'b0;
    wait_done(k);
    chk("bnd_done_latency", 32'(k), 32'd16);

    // Brightness duty cycle.
    bright = 4'h3;
    cycle(); cycle();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (digits != 4'hF) cnt++;
      cycle();
    end
    chk("bright3_duty", 32'(cnt), 32'd4);
    bright = 4'h0;
    cycle(); cycle();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (digits != 4'hF) cnt++;
      cycle();
    end
    chk("bright0_duty", 32'(cnt), 32'd1);
    bright = 4'hF;

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      upd_valid = ($urandom_range(0, 3) == 0);
      upd_value = 16'($urandom);
      upd_dp    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) bright = 4'($urandom_range(0, 15));
      cycle();
    end
    upd_valid = 1'b0;
    bright = 4'hF;

    // Reset while an update is pending discards it.
    wait_ready();
    wait_pos(2);
    upd_valid = 1'b1; upd_value = 16'h4321; upd_dp = 4'b1111;
    cycle();
    upd_valid = 1'b0;
    chk("rp_pending", 32'(upd_ready), 32'd0);
    cycle();
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    chk("rp_ready", 32'(upd_ready), 32'd1);
    chk("rp_digits", 32'(digits), 32'hE);
    chk("rp_segments", 32'(segments), 32'h3F);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (upd_done) cnt++;
      cycle();
    end
    chk("rp_no_done", 32'(cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
